// File: rtl/fpu_int_pkg.sv
// Shared definitions for the integer add/sub engines of the FPU datapath.
// Holds the sequencer state encoding and the op encoding used on in_op.
package fpu_int_pkg;

  // Sequencer states: waiting for operands, shifting bits, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation encoding on in_op / the cell op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : fpu_int_pkg

// File: rtl/addsub_bit_cell.sv
// One-bit full adder/subtractor.
// Subtraction is formed as A + ~B + cin: B is inverted when op selects
// subtract, and the sequencer seeds the carry with op so the first cin is 1.
module addsub_bit_cell
  import fpu_int_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic op,
  input  logic cin,
  output logic result,
  output logic cout
);

  logic b_eff;

  // Conditionally invert B, then a plain full-adder sum and majority carry.
  always_comb begin
    b_eff  = B ^ (op == OP_SUB);
    result = A ^ b_eff ^ cin;
    cout   = (A & b_eff) | (A & cin) | (b_eff & cin);
  end

endmodule : addsub_bit_cell

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer.
// Operands are accepted through a valid/ready handshake, then one bit pair
// per cycle (LSB first) goes through a single addsub_bit_cell while the
// carry is held in a register. The result is presented on valid/ready.
// Optional status flags (out_zero, out_ovf) are built when the macro
// SERIAL_ADDSUB_FLAGS_EN is defined.
module serial_addsub_ctrl
  import fpu_int_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             busy
`ifdef SERIAL_ADDSUB_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             op_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             cell_sum;
  logic             cell_cout;
  logic             accept;
  logic             last_bit;

  // The single arithmetic cell, fed from the bottom of the shift registers.
  addsub_bit_cell u_cell (
    .A      (a_sh[0]),
    .B      (b_sh[0]),
    .op     (op_q),
    .cin    (carry),
    .result (cell_sum),
    .cout   (cell_cout)
  );

  // Handshake qualifiers and the value the result register takes next.
  always_comb begin
    accept   = in_valid && (state == IDLE);
    last_bit = (state == RUN) && (cnt == LAST_CNT);
    res_nxt  = {cell_sum, res_sh[WIDTH-1:1]};
  end

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the handshake/status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per RUN cycle.
  // Nothing here moves in DONE, so the result is stable under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            op_q  <= in_op;
            carry <= in_op;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          carry  <= cell_cout;
          cnt    <= cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign out_result = res_sh;
  assign out_cout   = carry;

`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic zero_q;
  logic ovf_q;

  // Flags are registered on the last RUN cycle: the cell's cin there is the
  // carry into the MSB and its cout the carry out of the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_bit) begin
      zero_q <= (res_nxt == '0);
      ovf_q  <= carry ^ cell_cout;
    end
  end

  assign out_zero = zero_q;
  assign out_ovf  = ovf_q;
`else
  // Flag ports and logic are not built in this configuration.
`endif

endmodule : serial_addsub_ctrl

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8).
// Directed cases plus random operands, compared against an arithmetic model.
// Define SERIAL_ADDSUB_FLAGS_EN for both bench and RTL to cover the flags.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_cout;
  logic         busy;
`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic         out_zero;
  logic         out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .busy       (busy)
`ifdef SERIAL_ADDSUB_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One comparison: counts it, asserts equality, reports on failure.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model from plain integer arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                       output logic [W-1:0] res, output logic cout,
                       output logic zero, output logic ovf);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (op) begin
      ur   = ua - ub;
      sr   = sa - sb;
      cout = (ua >= ub);
    end else begin
      ur   = ua + ub;
      sr   = sa + sb;
      cout = (ur >= 256);
    end
    res  = W'(ur & 255);
    zero = (res == 0);
    ovf  = (sr > 127) || (sr < -128);
  endtask

  // One full transaction with latency, RUN, back-pressure and release checks.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                               input int stall, input bit pulse, input string tag);
    logic [W-1:0] er;
    logic ec, ez, eo;
    int n;
    logic [W-1:0] held;
    model(a, b, op, er, ec, ez, eo);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    if (!in_ready) return;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      if (n == 2) begin
        checkOutput({tag, "_run_ready"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_run_busy"}, 64'(busy), 64'd1);
      end
      if (pulse && n == 3) begin
        in_valid = 1'b1;
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_op = ~op;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, 64'(n), 64'(W + 1));
    checkOutput({tag, "_result"}, 64'(out_result), 64'(er));
    checkOutput({tag, "_cout"}, 64'(out_cout), 64'(ec));
`ifdef SERIAL_ADDSUB_FLAGS_EN
    checkOutput({tag, "_zero"}, 64'(out_zero), 64'(ez));
    checkOutput({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
`endif
    held = out_result;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_stall_result"}, 64'(out_result), 64'(held));
      checkOutput({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_release_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  // Directed sequence followed by random operations.
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_result", 64'(out_result), 64'd0);
    checkOutput("reset_cout", 64'(out_cout), 64'd0);
`ifdef SERIAL_ADDSUB_FLAGS_EN
    checkOutput("reset_zero", 64'(out_zero), 64'd0);
    checkOutput("reset_ovf", 64'(out_ovf), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'h35, 8'h4A, 1'b0, 0, 1'b0, "add_35_4a");
    applyStimulus(8'hFF, 8'h01, 1'b0, 0, 1'b0, "add_ff_01");
    applyStimulus(8'h10, 8'h20, 1'b1, 0, 1'b0, "sub_10_20");
    applyStimulus(8'h80, 8'h01, 1'b1, 0, 1'b0, "sub_80_01");
    applyStimulus(8'h5C, 8'h27, 1'b0, 5, 1'b0, "backpressure");
    applyStimulus(8'hA3, 8'h3C, 1'b1, 0, 1'b1, "pulse_in_run");

    // Abort an operation on its third RUN cycle.
    in_valid = 1'b1;
    in_a = 8'h55;
    in_b = 8'h33;
    in_op = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_result", 64'(out_result), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    applyStimulus(8'h01, 8'h01, 1'b0, 0, 1'b0, "after_abort");

    for (int k = 0; k < 24; k++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                    1'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule : tb_serial_addsub_ctrl

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer built around one 1-bit full-adder/subtractor cell.
- Accepts two WIDTH-bit operands and an op through a valid/ready handshake, then feeds one bit pair per cycle, LSB first, through the cell.
- Holds the running carry in a register, assembles the result, and presents it on a valid/ready output.
- Serves as the area-minimal integer add/sub engine for FPU mantissa and exponent paths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2 to 64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- out_cout  output  1  final carry; for subtract, 1 = no borrow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst has priority over all inputs):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_result=0, out_cout=0, internal carry/counter/shift registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a, b and op; carry<=op; cnt<=0; go to RUN.
  - in_valid without acceptance has no effect.
- RUN (exactly WIDTH cycles):
  - Each cycle, the cell gets A=a_sh[0], B=b_sh[0], op, cin=carry.
  - Cell output shifts into result MSB (right-shift register); carry<=cell cout; a_sh/b_sh shift right; cnt++.
  - On cnt==WIDTH-1, go to DONE.
  - in_ready=0; in_valid ignored.
- DONE:
  - out_valid=1; out_result and out_cout stable while out_valid high.
  - On out_ready, go to IDLE.
  - A new operand is not accepted in the same cycle as the result handshake.
- Timing:
  - Input handshake at cycle t gives out_valid at t+WIDTH+1.
  - in_ready returns at t+WIDTH+2 at the earliest, so peak throughput is one op per WIDTH+2 cycles.
- Arithmetic:
  - Subtract is A + ~B + 1, done by XOR of B with op inside the cell and initial carry=op.
  - Result wraps modulo 2^WIDTH.
- Output back-pressure: out_ready low holds DONE indefinitely with no change to outputs.
- Reset mid-RUN or mid-DONE aborts the operation and clears to reset values; in_ready=1 the next cycle.
- out_result holds its last value in IDLE; it is meaningful only while out_valid=1.

Optional Feature:
- Macro: SERIAL_ADDSUB_FLAGS_EN.
- Defined:
  - Adds out_zero (1 when out_result==0).
  - Adds out_ovf (signed two's-complement overflow = carry into MSB XOR carry out of MSB; carry into MSB is latched on the last RUN cycle).
  - Both reset to 0 and are valid alongside out_valid.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package fpu_int_pkg:
  - State enum (IDLE/RUN/DONE).
  - Op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, addsub_bit_cell:
  - Purely combinational 1-bit full adder/subtractor.
  - Ports A, B, op, cin, result, cout.
  - Instantiated once.

Test Plan (WIDTH=8):
- Add 8'h35 + 8'h4A, out_ready=1 → out_valid exactly 9 cycles after the accept; result 8'h7F, cout 0, ovf 0, zero 0.
- Add 8'hFF + 8'h01 → result 8'h00, cout 1, zero 1, ovf 0.
- Sub 8'h10 - 8'h20 → result 8'hF0, cout 0 (borrow); then sub 8'h80 - 8'h01 → result 8'h7F, cout 1, ovf 1.
- Back-pressure: out_ready low for 5 cycles in DONE → out_valid stays 1, outputs stable, in_ready 0; out_ready high → in_ready=1 the following cycle.
- in_valid pulsed with new operands during RUN → ignored; the first operation's result is unchanged.
- rst asserted on the 3rd RUN cycle → next cycle in_ready=1, out_valid=0, out_result=0; a new 8'h01 + 8'h01 then yields 8'h02.
